// File: rtl/acorn128_ctrl.sv
// ACORN-128 bit-serial phase sequencer.
// Walks init -> AD (+pad) -> message (+pad) -> finalization and feeds the
// state update stage with ca/cb/mbit plus a step enable, one bit per step.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; all outputs low (done pulses here)
// S_INIT    | key/IV load, 1792 unconditional steps
// S_AD      | associated data, one step per accepted AD bit
// S_AD_PAD  | AD padding, 256 steps (leading 1 bit, ca high for 128)
// S_MSG     | message, one step per accepted message bit
// S_MSG_PAD | message padding, as AD padding but cb low
// S_FINAL   | finalization, 768 steps, last 128 form the tag window

module acorn128_ctrl #(
  parameter int unsigned INIT_STEPS   = 1792,
  parameter int unsigned PAD_STEPS    = 256,
  parameter int unsigned PAD_CA_STEPS = 128,
  parameter int unsigned FINAL_STEPS  = 768
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] iv_i,
  input  logic         ad_zero_i,
  input  logic         pt_zero_i,
  input  logic         dec_i,
  input  logic         ad_valid_i,
  input  logic         ad_bit_i,
  input  logic         ad_last_i,
  output logic         ad_ready_o,
  input  logic         pt_valid_i,
  input  logic         pt_bit_i,
  input  logic         pt_last_i,
  output logic         pt_ready_o,
  input  logic         ks_in_i,
  output logic         ca_out_o,
  output logic         cb_out_o,
  output logic         mbit_out_o,
  output logic         step_en_o,
  output logic         tag_win_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_AD_PAD, S_MSG, S_MSG_PAD, S_FINAL
  } state_t;

  localparam logic [10:0] INIT_LAST  = 11'(INIT_STEPS - 1);
  localparam logic [10:0] PAD_LAST   = 11'(PAD_STEPS - 1);
  localparam logic [10:0] PAD_CA_END = 11'(PAD_CA_STEPS);
  localparam logic [10:0] FINAL_LAST = 11'(FINAL_STEPS - 1);
  localparam logic [10:0] TAG_FIRST  = 11'(FINAL_STEPS - 128);

  state_t       state_q, state_d;
  logic [10:0]  cnt_q, cnt_d;
  logic [127:0] key_q, iv_q;
  logic         ad_zero_q, pt_zero_q, dec_q;
  logic         done_q, done_d;
  logic         init_mbit;

  // State, counter and done pulse registers; operation parameters latch on an accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      key_q     <= '0;
      iv_q      <= '0;
      ad_zero_q <= 1'b0;
      pt_zero_q <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && start_i) begin
        key_q     <= key_i;
        iv_q      <= iv_i;
        ad_zero_q <= ad_zero_i;
        pt_zero_q <= pt_zero_i;
        dec_q     <= dec_i;
      end
    end
  end

  // Init message bit: key, then IV, then a single inverted key bit 0, then key repeated.
  always_comb begin
    init_mbit = key_q[cnt_q[6:0]];
    if (cnt_q < 11'd128)       init_mbit = key_q[cnt_q[6:0]];
    else if (cnt_q < 11'd256)  init_mbit = iv_q[cnt_q[6:0]];
    else if (cnt_q == 11'd256) init_mbit = ~key_q[0];
  end

  // Next-state and phase outputs; counter restarts on every state change.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    ad_ready_o = 1'b0;
    pt_ready_o = 1'b0;
    ca_out_o   = 1'b0;
    cb_out_o   = 1'b0;
    mbit_out_o = 1'b0;
    step_en_o  = 1'b0;
    tag_win_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_INIT;
      end
      S_INIT: begin
        step_en_o  = 1'b1;
        ca_out_o   = 1'b1;
        cb_out_o   = 1'b1;
        mbit_out_o = init_mbit;
        if (cnt_q == INIT_LAST) state_d = ad_zero_q ? S_AD_PAD : S_AD;
      end
      S_AD: begin
        ad_ready_o = 1'b1;
        ca_out_o   = 1'b1;
        cb_out_o   = 1'b1;
        mbit_out_o = ad_bit_i;
        step_en_o  = ad_valid_i;
        if (ad_valid_i && ad_last_i) state_d = S_AD_PAD;
      end
      S_AD_PAD: begin
        step_en_o  = 1'b1;
        mbit_out_o = (cnt_q == 11'd0);
        ca_out_o   = (cnt_q < PAD_CA_END);
        cb_out_o   = 1'b1;
        if (cnt_q == PAD_LAST) state_d = pt_zero_q ? S_MSG_PAD : S_MSG;
      end
      S_MSG: begin
        pt_ready_o = 1'b1;
        ca_out_o   = 1'b1;
        cb_out_o   = 1'b0;
        step_en_o  = pt_valid_i;
        mbit_out_o = pt_bit_i ^ (dec_q & ks_in_i);
        if (pt_valid_i && pt_last_i) state_d = S_MSG_PAD;
      end
      S_MSG_PAD: begin
        step_en_o  = 1'b1;
        mbit_out_o = (cnt_q == 11'd0);
        ca_out_o   = (cnt_q < PAD_CA_END);
        cb_out_o   = 1'b0;
        if (cnt_q == PAD_LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        step_en_o  = 1'b1;
        ca_out_o   = 1'b1;
        cb_out_o   = 1'b1;
        tag_win_o  = (cnt_q >= TAG_FIRST);
        if (cnt_q == FINAL_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (step_en_o)     cnt_d = cnt_q + 11'd1;
    else                    cnt_d = cnt_q;
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Self-checking bench for acorn128_ctrl: a step-stream reference model built
// from the phase rules, a decrypt/stall vector table, and hand sequences for
// reset abort, init pattern, zero lengths, AD stalls and the tag window.

module tb_acorn128_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, ad_zero, pt_zero, dec;
  logic [127:0] key, iv;
  logic         ad_valid, ad_bit, ad_last, ad_ready;
  logic         pt_valid, pt_bit, pt_last, pt_ready;
  logic         ks_in, ca, cb, mbit, step_en, tag_win, busy, done;

  always #5 clk = ~clk;

  acorn128_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key), .iv_i(iv),
    .ad_zero_i(ad_zero), .pt_zero_i(pt_zero), .dec_i(dec),
    .ad_valid_i(ad_valid), .ad_bit_i(ad_bit), .ad_last_i(ad_last), .ad_ready_o(ad_ready),
    .pt_valid_i(pt_valid), .pt_bit_i(pt_bit), .pt_last_i(pt_last), .pt_ready_o(pt_ready),
    .ks_in_i(ks_in), .ca_out_o(ca), .cb_out_o(cb), .mbit_out_o(mbit),
    .step_en_o(step_en), .tag_win_o(tag_win), .busy_o(busy), .done_o(done)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit ca, cb, mbit, is_msg, tag;
  } step_t;

  step_t exp_q[$];
  bit    ad_src[$];
  bit    pt_src[$];

  typedef struct {
    bit valid, pbit, ks;
    bit e_step, e_mbit;
  } vec_t;

  // Expected sequence of steps for a whole operation, straight from the phase rules.
  task automatic build_model(input logic [127:0] k, input logic [127:0] v);
    bit mb;
    exp_q.delete();
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       mb = k[i];
      else if (i < 256)  mb = v[i-128];
      else if (i == 256) mb = ~k[0];
      else               mb = k[i % 128];
      exp_q.push_back('{1'b1, 1'b1, mb, 1'b0, 1'b0});
    end
    foreach (ad_src[i]) exp_q.push_back('{1'b1, 1'b1, ad_src[i], 1'b0, 1'b0});
    for (int i = 0; i < 256; i++) exp_q.push_back('{i < 128, 1'b1, i == 0, 1'b0, 1'b0});
    foreach (pt_src[i]) exp_q.push_back('{1'b1, 1'b0, pt_src[i], 1'b1, 1'b0});
    for (int i = 0; i < 256; i++) exp_q.push_back('{i < 128, 1'b0, i == 0, 1'b0, 1'b0});
    for (int i = 0; i < 768; i++) exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, i >= 640});
  endtask

  task automatic idle_inputs();
    start = 0; ad_valid = 0; ad_bit = 0; ad_last = 0;
    pt_valid = 0; pt_bit = 0; pt_last = 0; ks_in = 0;
  endtask

  // mode 0: valid always high, 1: valid toggles every cycle, 2: random valid and stray starts
  task automatic run_op(input logic [127:0] k, input logic [127:0] v, input bit dc, input int mode);
    bit    adz, ptz, got_done;
    int    total, cyc, ai, pi, tags, last_tag;
    step_t e;
    bit    em;
    adz = (ad_src.size() == 0);
    ptz = (pt_src.size() == 0);
    build_model(k, v);
    total = exp_q.size();
    cyc = 0; ai = 0; pi = 0; tags = 0; last_tag = -1; got_done = 0;
    @(posedge clk); #1;
    key = k; iv = v; ad_zero = adz; pt_zero = ptz; dec = dc; start = 1;
    @(posedge clk); #1;
    start = 0; key = ~k; iv = ~v; ad_zero = ~adz; pt_zero = ~ptz; dec = ~dc;
    while (!got_done && cyc < 20000) begin
      cyc++;
      if (ai < ad_src.size())
        ad_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      else ad_valid = 0;
      ad_bit  = (ai < ad_src.size()) ? ad_src[ai] : 1'($urandom_range(0, 1));
      ad_last = (ai == ad_src.size() - 1);
      if (pi < pt_src.size())
        pt_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      else pt_valid = 0;
      pt_bit  = (pi < pt_src.size()) ? pt_src[pi] : 1'($urandom_range(0, 1));
      pt_last = (pi == pt_src.size() - 1);
      ks_in   = 1'($urandom_range(0, 1));
      start   = (mode == 2 && exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (step_en) begin
        if (exp_q.size() == 0) chk("extra_step", 1, 0);
        else begin
          e  = exp_q.pop_front();
          em = e.is_msg ? (e.mbit ^ (dc & ks_in)) : e.mbit;
          chk("step", {ca, cb, mbit, tag_win}, {e.ca, e.cb, em, e.tag});
        end
        if (tag_win) begin tags++; last_tag = cyc; end
      end else if (busy && ad_ready) begin
        chk("ad_stall", {ca, cb, mbit, ad_valid, pt_ready}, {1'b1, 1'b1, ad_bit, 1'b0, 1'b0});
      end else if (busy && pt_ready) begin
        chk("msg_stall", {ca, cb, mbit, pt_valid, ad_ready},
            {1'b1, 1'b0, pt_bit ^ (dc & ks_in), 1'b0, 1'b0});
      end
      if (ad_valid && ad_ready) ai++;
      if (pt_valid && pt_ready) pi++;
      if (done) got_done = 1;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("done_seen", got_done, 1);
    chk("steps_left", exp_q.size(), 0);
    chk("ad_taken", ai, ad_src.size());
    chk("pt_taken", pi, pt_src.size());
    chk("tag_count", tags, 128);
    chk("tag_then_done", last_tag, cyc - 1);
    if (mode == 0) chk("latency", cyc, total + 1);
    @(negedge clk);
    chk("after_done", {done, busy, step_en, ca, cb, mbit}, 0);
  endtask

  vec_t vecs[8];
  int   done_cnt;
  bit   reached;

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 1};
    vecs[2] = '{0, 1, 1, 0, 0};
    vecs[3] = '{1, 1, 1, 1, 0};
    vecs[4] = '{1, 0, 1, 1, 1};
    vecs[5] = '{1, 1, 0, 1, 1};
    vecs[6] = '{1, 0, 0, 1, 0};
    vecs[7] = '{0, 0, 1, 0, 1};

    idle_inputs();
    rst = 1; key = '0; iv = '0; ad_zero = 0; pt_zero = 0; dec = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {ca, cb, mbit, step_en, tag_win, busy, done, ad_ready, pt_ready}, 0);
    @(posedge clk); #1;
    rst = 0;

    // Init pattern with key=1, then abort with reset at INIT cnt 500.
    key = 128'h1; iv = '0; ad_zero = 0; pt_zero = 0; dec = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 501; c++) begin
      @(negedge clk);
      if (c == 1)   chk("init_cnt0",   {step_en, mbit}, 2'b11);
      if (c == 257) chk("init_cnt256", {step_en, mbit}, 2'b10);
      if (c == 385) chk("init_cnt384", {step_en, mbit}, 2'b11);
      if (c == 501) chk("init_cnt500_busy", {busy, ca, cb}, 3'b111);
      @(posedge clk); #1;
      if (c == 500) rst = 1;
    end
    @(negedge clk);
    chk("abort_outputs", {ca, cb, mbit, step_en, tag_win, busy, done, ad_ready, pt_ready}, 0);
    @(posedge clk); #1;
    rst = 0;
    done_cnt = 0;
    for (int c = 0; c < 3200; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);

    // Zero lengths with the init-pattern key.
    ad_src.delete(); pt_src.delete();
    run_op(128'h1, '0, 1'b0, 0);

    // AD of 8'hA5 (MSB first) with ad_valid toggling, short message.
    ad_src = '{1, 0, 1, 0, 0, 1, 0, 1};
    pt_src = '{1, 1, 0};
    run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1);

    // Decrypt/stall vectors applied while parked in MSG with dec latched high.
    @(posedge clk); #1;
    key = '0; iv = '0; ad_zero = 1; pt_zero = 0; dec = 1; start = 1;
    @(posedge clk); #1;
    start = 0; dec = 0;
    reached = 0;
    for (int c = 0; c < 3000 && !reached; c++) begin
      @(negedge clk);
      if (pt_ready) reached = 1;
      @(posedge clk); #1;
    end
    chk("reach_msg", reached, 1);
    for (int i = 0; i < 8; i++) begin
      pt_valid = vecs[i].valid; pt_bit = vecs[i].pbit; ks_in = vecs[i].ks; pt_last = 0;
      @(negedge clk);
      chk($sformatf("msg_vec%0d", i), {step_en, mbit, ca, cb, pt_ready, ad_ready, busy},
          {vecs[i].e_step, vecs[i].e_mbit, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("reset_from_msg", {busy, pt_ready, done}, 0);

    // Randomized operations against the step-stream model.
    for (int r = 0; r < 6; r++) begin
      int al, ml;
      ad_src.delete(); pt_src.delete();
      al = (r == 0) ? 0 : $urandom_range(1, 20);
      ml = (r == 1) ? 0 : $urandom_range(1, 20);
      for (int i = 0; i < al; i++) ad_src.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < ml; i++) pt_src.push_back(1'($urandom_range(0, 1)));
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), (r < 2) ? 0 : 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
